dmem_arb: RTL and testbench
===========================

DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
  DATA_W  `DATA_W (def.h)  data word width
  ADDR_W  16  word address width
  LOCK_MAX  8  maximum consecutive locked grants to one master
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, asynchronous, active-low
  mN_req  in  1  master N (N=0,1) access request
  mN_we  in  1  master N write enable
  mN_lock  in  1  master N requests to keep ownership after this access
  mN_a  in  ADDR_W  master N word address
  mN_wd  in  DATA_W  master N write data
  mN_gnt  out  1  master N access performed this cycle
  mN_rvalid  out  1  master N read data valid
  mN_rd  out  DATA_W  master N read data, registered
  mem_a  out  ADDR_W  dmem address
  mem_we  out  1  dmem write enable
  mem_wd  out  DATA_W  dmem write data
  mem_rd  in  DATA_W  dmem combinational read data

Function
REQ-003 At most one of m0_gnt and m1_gnt SHALL be high in any cycle; a high mN_gnt means the selected master's a/we/wd drive mem_a/mem_we/mem_wd that cycle.
REQ-004 mN_gnt SHALL be combinational from the mN_req inputs, FSM state and rr pointer; mN_gnt SHALL never be high while mN_req is low.
REQ-005 In IDLE with one request pending, that master SHALL be granted; with both pending, the master not granted most recently (rr pointer) SHALL be granted.
REQ-006 The rr pointer SHALL update to the granted master on every grant; reset value points to master 1, so master 0 wins the first tie.
REQ-007 With no grant, mem_we SHALL be 0 and mem_a/mem_wd SHALL be 0.
REQ-008 Writes SHALL complete in the grant cycle; the master drops or changes its request after sampling gnt high.
REQ-009 For a granted read (we=0), mN_rd SHALL capture mem_rd at that clock edge and mN_rvalid SHALL be high for exactly the following cycle; mN_rd holds its value until the next read grant to that master.
REQ-010 FSM states SHALL be IDLE, OWN0, OWN1.
REQ-011 IDLE->OWNn when master n is granted with mn_lock=1; otherwise stay IDLE.
REQ-012 In OWNn only master n SHALL be grantable; the other master waits even if requesting.
REQ-013 OWNn->IDLE when master n is granted with lock=0, when mn_req is low, or when the lock counter reaches LOCK_MAX.
REQ-014 The lock counter SHALL clear on entering OWNn and increment per grant in OWNn; the LOCK_MAX-th locked grant SHALL still be performed, then the FSM returns to IDLE and rr gives the other master priority.
REQ-015 A request that deasserts without a grant SHALL leave no state change besides REQ-013.

Reset
REQ-016 On rst_n low, asynchronously: state=IDLE, rr pointer=1, lock counter=0, mN_rvalid=0, mN_rd=0.
REQ-017 Reset asserted mid-lock SHALL drop ownership; no grant in any cycle where rst_n is low.
REQ-018 Reset released mid-cycle SHALL not produce a spurious grant before the first rising edge with rst_n high.

Structure
REQ-019 DATA_W, ADDR_W and LOCK_MAX defaults SHALL live in the shared def.h header, and the FSM state encodings as named constants there.
REQ-020 The two-way round-robin select SHALL be a sub-module dmem_arb_pick (inputs req[1:0], rr, owner mask; output one-hot grant).

Verification
REQ-021 Reset, then m0 read a=0 only -> m0_gnt same cycle, next cycle m0_rvalid=1, m0_rd=mem[0].
REQ-022 Both masters request continuously, no lock -> grants alternate m0,m1,m0,m1 from the first cycle.
REQ-023 m0 locked writes a=1..20, m1 requesting -> m0 gets exactly 8 grants, then m1 granted, then m0 resumes.
REQ-024 m1 write a=5 wd=0xDEADBEEF, then m0 read a=5 -> m0_rd=0xDEADBEEF one cycle after m0_gnt.
REQ-025 rst_n low during OWN0 with m1 requesting -> no grants while low; after release m0 wins the first tie, m1_rvalid=0.
REQ-026 Every run: assertion that m0_gnt and m1_gnt are never both high and mem_we=0 whenever no grant.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared defaults and FSM encodings for the two-master data-memory arbiter.
// Holds the DATA_W/ADDR_W/LOCK_MAX defaults and state constants the arbiter files import.
package dmem_arb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_LOCK_MAX = 8;
  localparam int NUM_MST      = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Masters allowed to win arbitration in a given state.
  function automatic logic [NUM_MST-1:0] own_mask(input arb_state_e s);
    case (s)
      ST_OWN0: own_mask = 2'b01;
      ST_OWN1: own_mask = 2'b10;
      default: own_mask = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way round-robin select: rr names the master granted most recently,
// so on a tie the other one wins.
module dmem_arb_pick (
  input  logic [1:0] req,
  input  logic       rr,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] elig;
  assign elig = req & mask;

  always_comb begin
    gnt = elig;
    if (&elig) gnt = rr ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/dmem_arb.sv
// Two-master dmem arbiter: combinational grant, round-robin tie break,
// bounded lock ownership and registered per-master read return.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LOCK_MAX = DEF_LOCK_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_a,
  input  logic [DATA_W-1:0] m0_wd,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rd,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_a,
  input  logic [DATA_W-1:0] m1_wd,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rd,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [NUM_MST-1:0]             req, we, lock, pick, gnt, rvalid_q;
  logic [NUM_MST-1:0][ADDR_W-1:0] a;
  logic [NUM_MST-1:0][DATA_W-1:0] wd, rd_q;

  assign req  = {m1_req, m0_req};
  assign we   = {m1_we, m0_we};
  assign lock = {m1_lock, m0_lock};
  assign a    = {m1_a, m0_a};
  assign wd   = {m1_wd, m0_wd};

  arb_state_e       state;
  logic             rr;
  logic             run;
  logic [CNT_W-1:0] lock_cnt;
  logic             own_idx;

  assign own_idx = (state == ST_OWN1);

  dmem_arb_pick u_pick (
    .req  (req),
    .rr   (rr),
    .mask (own_mask(state)),
    .gnt  (pick)
  );

  // run holds grants off until the first rising edge after reset release.
  assign gnt    = (run && rst_n) ? pick : '0;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (gnt[i]) begin
        mem_a  = a[i];
        mem_we = we[i];
        mem_wd = wd[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr       <= 1'b1;
      run      <= 1'b0;
      lock_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (|gnt) rr <= gnt[1];
      case (state)
        ST_IDLE: begin
          if (|gnt && lock[gnt[1]] && LOCK_MAX > 1) begin
            state    <= gnt[1] ? ST_OWN1 : ST_OWN0;
            lock_cnt <= '0;
          end
        end
        default: begin
          // The entry grant counts as the first locked grant.
          if (!req[own_idx]) begin
            state <= ST_IDLE;
          end else if (gnt[own_idx]) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
            if (!lock[own_idx] || int'(lock_cnt) >= LOCK_MAX - 2) state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= '0;
      rd_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        rvalid_q[i] <= gnt[i] & ~we[i];
        if (gnt[i] && !we[i]) rd_q[i] <= mem_rd;
      end
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rd     = rd_q[0];
  assign m1_rd     = rd_q[1];

endmodule

// File: tb/tb_dmem_arb.sv
// Directed bench for dmem_arb: stimulus pushes expected grants and read data
// into queues, a negedge monitor pops and compares.
module tb_dmem_arb;
  import dmem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk, rst_n;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m0_a, m1_a, mem_a;
  logic [DW-1:0] m0_wd, m1_wd, m0_rd, m1_rd, mem_wd, mem_rd;
  logic          mem_we;

  dmem_arb #(.DATA_W(DW), .ADDR_W(AW), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_a(m0_a), .m0_wd(m0_wd),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_a(m1_a), .m1_wd(m1_wd),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rd(m1_rd),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  assign mem_rd = mem[mem_a[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:0]] <= mem_wd;

  typedef struct { int m; logic [AW-1:0] a; } gexp_t;
  gexp_t         gq[$];
  logic [DW-1:0] rdq0[$], rdq1[$];
  gexp_t         mon_e;
  logic [DW-1:0] mon_d;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_g(input int m, input int adr);
    gexp_t e;
    e.m = m;
    e.a = AW'(adr);
    gq.push_back(e);
  endtask

  // Monitor: exclusivity/idle-bus property every cycle, then queue checks.
  always @(negedge clk) begin
    total++;
    a_excl: assert (!(m0_gnt && m1_gnt) && (m0_gnt || m1_gnt || !mem_we)) else begin
      bad++;
      $display("FAIL excl: gnt=%b%b mem_we=%b want exclusive and idle we=0", m1_gnt, m0_gnt, mem_we);
    end
    if (m0_gnt || m1_gnt) begin
      if (gq.size() == 0) chk("gnt_unexpected", {m1_gnt, m0_gnt}, 0);
      else begin
        mon_e = gq.pop_front();
        chk("gnt_master", m1_gnt ? 1 : 0, mon_e.m);
        chk("gnt_addr", mem_a, mon_e.a);
      end
    end
    if (m0_rvalid) begin
      if (rdq0.size() == 0) chk("m0_rvalid_unexpected", 1, 0);
      else begin mon_d = rdq0.pop_front(); chk("m0_rd", m0_rd, mon_d); end
    end
    if (m1_rvalid) begin
      if (rdq1.size() == 0) chk("m1_rvalid_unexpected", 1, 0);
      else begin mon_d = rdq1.pop_front(); chk("m1_rd", m1_rd, mon_d); end
    end
  end

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_lock = 0; m0_a = '0; m0_wd = '0;
    m1_req = 0; m1_we = 0; m1_lock = 0; m1_a = '0; m1_wd = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Each master keeps requesting until it has received its quota of grants.
  task automatic run(input int n0_i, input int n1_i, input bit inc0);
    int n0, n1, cyc;
    bit g0, g1;
    n0 = n0_i; n1 = n1_i; cyc = 0;
    while ((n0 > 0 || n1 > 0) && cyc < 400) begin
      m0_req = (n0 > 0);
      m1_req = (n1 > 0);
      @(negedge clk);
      g0 = m0_gnt; g1 = m1_gnt;
      @(posedge clk); #1;
      cyc++;
      if (g0) begin
        n0--;
        if (inc0) begin m0_a = m0_a + 1'b1; m0_wd = {16'hC000, m0_a}; end
      end
      if (g1) n1--;
    end
    m0_req = 0; m1_req = 0;
    total++;
    if (n0 > 0 || n1 > 0) begin
      bad++;
      $display("FAIL run_timeout: left m0=%0d m1=%0d want 0 0", n0, n1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    m0_req = 1; m1_req = 1;
    #10;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rd", m0_rd, 0);
    chk("rst_m1_rd", m1_rd, 0);
    chk("rst_mem_we", mem_we, 0);
    m0_req = 0; m1_req = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Both continuously requesting: m0 wins the first tie, then alternate.
    m0_a = 16'd2; m1_a = 16'd3;
    push_g(0, 2); push_g(1, 3); push_g(0, 2); push_g(1, 3);
    rdq0.push_back(32'hA000_0002); rdq0.push_back(32'hA000_0002);
    rdq1.push_back(32'hA000_0003); rdq1.push_back(32'hA000_0003);
    run(2, 2, 0);
    repeat (2) @(posedge clk); #1;

    // Single read of address 0 right after reset.
    do_reset();
    idle_inputs();
    push_g(0, 0); rdq0.push_back(32'hA000_0000);
    run(1, 0, 0);
    chk("t1_m0_rvalid", m0_rvalid, 1);
    chk("t1_m0_rd", m0_rd, 32'hA000_0000);
    repeat (2) @(posedge clk); #1;

    // Locked write burst with m1 waiting: 8 grants, m1 once, then m0 resumes.
    do_reset();
    m0_lock = 1; m0_we = 1; m0_a = 16'd1; m0_wd = {16'hC000, 16'd1};
    m1_a = 16'd30;
    for (int k = 1; k <= 8; k++) push_g(0, k);
    push_g(1, 30);
    for (int k = 9; k <= 20; k++) push_g(0, k);
    rdq1.push_back(32'hA000_001E);
    run(20, 1, 1);
    idle_inputs();
    chk("t3_mem20", mem[20], 32'hC000_0014);
    chk("t3_mem8", mem[8], 32'hC000_0008);
    repeat (2) @(posedge clk); #1;

    // m1 writes, m0 reads the same word back.
    m1_we = 1; m1_a = 16'd5; m1_wd = 32'hDEAD_BEEF;
    push_g(1, 5);
    run(0, 1, 0);
    m1_we = 0;
    m0_a = 16'd5;
    push_g(0, 5); rdq0.push_back(32'hDEAD_BEEF);
    run(1, 0, 0);
    chk("t4_m0_rvalid", m0_rvalid, 1);
    chk("t4_m0_rd", m0_rd, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk); #1;

    // Reset while m0 owns the bus and m1 is waiting.
    do_reset();
    idle_inputs();
    m0_lock = 1; m0_we = 1; m0_a = 16'd40; m0_wd = 32'hC000_0028;
    m1_a = 16'd41;
    push_g(0, 40); push_g(0, 40);
    m0_req = 1; m1_req = 1;
    repeat (2) begin @(negedge clk); @(posedge clk); #1; end
    rst_n = 1'b0;
    m0_lock = 0; m0_we = 0; m0_a = 16'd42;
    push_g(0, 42); push_g(1, 41);
    rdq0.push_back(32'hA000_002A); rdq1.push_back(32'hA000_0029);
    repeat (3) begin
      @(negedge clk);
      chk("t5_low_m0_gnt", m0_gnt, 0);
      chk("t5_low_m1_gnt", m1_gnt, 0);
    end
    #2 rst_n = 1'b1;
    #1;
    chk("t5_rel_m0_gnt", m0_gnt, 0);
    chk("t5_rel_m1_gnt", m1_gnt, 0);
    chk("t5_rel_m1_rvalid", m1_rvalid, 0);
    @(posedge clk); #1;
    run(1, 1, 0);
    idle_inputs();
    repeat (3) @(posedge clk); #1;

    chk("gq_empty", gq.size(), 0);
    chk("rdq0_empty", rdq0.size(), 0);
    chk("rdq1_empty", rdq1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
